// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential RISC-V M-extension unit.
package muldiv_pkg;

    // Operation select, encoded exactly as the instruction funct3 field.
    typedef enum logic [2:0] {
        op_mul    = 3'd0,
        op_mulh   = 3'd1,
        op_mulhsu = 3'd2,
        op_mulhu  = 3'd3,
        op_div    = 3'd4,
        op_divu   = 3'd5,
        op_rem    = 3'd6,
        op_remu   = 3'd7
    } funct3_t;

    // Controller states.
    typedef enum logic [1:0] {
        st_idle   = 2'd0,
        st_calc   = 2'd1,
        st_finish = 2'd2
    } state_t;

    // Most negative 32-bit value; the dividend of the signed-overflow case.
    localparam logic [31:0] ovf_const = 32'h8000_0000;

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the pipeline and the multiply/divide unit.
//
// Handshake: the pipeline raises start for one cycle with funct3/rs1/rs2
// valid; it is accepted only while busy=0 and done=0 (unit idle). busy stays
// high from the cycle after acceptance until the done cycle inclusive. done
// is a single-cycle pulse with result valid in that same cycle; result then
// holds its value until the next operation completes. dbg_state mirrors the
// controller state for observation only.
interface muldiv_if #(
    parameter int XLEN = 32
);
    import muldiv_pkg::*;

    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    state_t          dbg_state;

    modport master (
        output start, funct3, rs1, rs2,
        input  busy, done, result, dbg_state
    );

    modport slave (
        input  start, funct3, rs1, rs2,
        output busy, done, result, dbg_state
    );

endinterface

// File: rtl/muldiv_iter.sv
// One combinational step of either radix-2 shift-add multiply or restoring
// divide. The accumulator is shared: for multiply it holds
// {partial_product_hi, multiplier_remaining}; for divide it holds
// {partial_remainder, dividend_remaining/quotient_bits}.
module muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc_in,
    input  logic [XLEN-1:0]   opnd,
    output logic [2*XLEN-1:0] acc_out
);
    logic [XLEN:0] add_sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // Compute both candidate steps and select by operation class.
    always_comb begin
        // Multiply: add multiplicand when the current multiplier bit is set,
        // then shift the whole product right by one (carry kept in the MSB).
        add_sum = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, opnd} : '0);
        // Divide: shift next dividend bit into the partial remainder and try
        // subtracting the divisor; a borrow (MSB set) means restore.
        shifted = {acc_in[2*XLEN-1:XLEN], acc_in[XLEN-1]};
        diff    = shifted - {1'b0, opnd};
        if (is_div) begin
            if (!diff[XLEN]) begin
                acc_out = {diff[XLEN-1:0], acc_in[XLEN-2:0], 1'b1};
            end else begin
                acc_out = {shifted[XLEN-1:0], acc_in[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_out = {add_sum, acc_in[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential RISC-V M-extension multiply/divide unit. Operands are latched
// on start, converted to magnitudes in a load cycle, iterated XLEN times
// through muldiv_iter, and sign-corrected when the result is presented.
// Divide-by-zero and signed overflow bypass the iteration entirely.
// Valid for 32 <= XLEN <= 64 (6-bit iteration counter, 32-bit overflow seed).
import muldiv_pkg::*;

module muldiv_seq #(
    parameter int XLEN = 32
) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);
    localparam logic [XLEN-1:0] int_min   = XLEN'(ovf_const) << (XLEN - 32);
    localparam logic [5:0]      last_iter = 6'(XLEN - 1);

    state_t            state;
    state_t            state_nxt;
    funct3_t           op_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [XLEN-1:0]   opnd_q;
    logic [XLEN-1:0]   res_q;
    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] acc_step;
    logic [5:0]        cnt_q;
    logic              loaded_q;

    logic              is_div;
    logic              is_rem;
    logic              a_signed;
    logic              b_signed;
    logic              neg_a;
    logic              neg_b;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   fin_val;

    // True when the operation is resolved without iterating.
    function automatic logic is_special(input funct3_t f,
                                        input logic [XLEN-1:0] a,
                                        input logic [XLEN-1:0] b);
        logic div_zero;
        logic ovf;
        div_zero = f[2] && (b == '0);
        ovf      = ((f == op_div) || (f == op_rem)) && (a == int_min) && (b == '1);
        return div_zero || ovf;
    endfunction

    muldiv_iter #(.XLEN(XLEN)) u_iter (
        .is_div  (is_div),
        .acc_in  (acc_q),
        .opnd    (opnd_q),
        .acc_out (acc_step)
    );

    // Operand classification and magnitudes from the latched request.
    always_comb begin
        is_div   = op_q[2];
        is_rem   = op_q[2] && op_q[1];
        a_signed = op_q inside {op_mul, op_mulh, op_mulhsu, op_div, op_rem};
        b_signed = op_q inside {op_mul, op_mulh, op_div, op_rem};
        neg_a    = a_signed && a_q[XLEN-1];
        neg_b    = b_signed && b_q[XLEN-1];
        mag_a    = neg_a ? -a_q : a_q;
        mag_b    = neg_b ? -b_q : b_q;
    end

    // Final sign fix-up and special-case substitution.
    always_comb begin
        prod_signed = (neg_a ^ neg_b) ? -acc_q : acc_q;
        quo         = acc_q[XLEN-1:0];
        rem         = acc_q[2*XLEN-1:XLEN];
        fin_val     = '0;
        if (is_div && (b_q == '0)) begin
            fin_val = is_rem ? a_q : '1;
        end else if (is_special(op_q, a_q, b_q)) begin
            fin_val = is_rem ? '0 : int_min;
        end else if (is_div) begin
            if (is_rem) begin
                fin_val = neg_a ? -rem : rem;
            end else begin
                fin_val = (neg_a ^ neg_b) ? -quo : quo;
            end
        end else if (op_q == op_mul) begin
            fin_val = prod_signed[XLEN-1:0];
        end else begin
            fin_val = prod_signed[2*XLEN-1:XLEN];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= st_idle;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            st_idle: begin
                if (bus.start) begin
                    if (is_special(funct3_t'(bus.funct3), bus.rs1, bus.rs2)) begin
                        state_nxt = st_finish;
                    end else begin
                        state_nxt = st_calc;
                    end
                end
            end
            st_calc: begin
                if (loaded_q && (cnt_q == last_iter)) begin
                    state_nxt = st_finish;
                end
            end
            st_finish: state_nxt = st_idle;
            default:   state_nxt = st_idle;
        endcase
    end

    // Outputs: result is presented combinationally during the done cycle and
    // held from the result register afterwards.
    always_comb begin
        bus.busy      = (state != st_idle);
        bus.done      = (state == st_finish);
        bus.result    = (state == st_finish) ? fin_val : res_q;
        bus.dbg_state = state;
    end

    // Datapath: latch request, load magnitudes, iterate, capture result.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= op_mul;
            a_q      <= '0;
            b_q      <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            loaded_q <= 1'b0;
            res_q    <= '0;
        end else begin
            case (state)
                st_idle: begin
                    if (bus.start) begin
                        op_q     <= funct3_t'(bus.funct3);
                        a_q      <= bus.rs1;
                        b_q      <= bus.rs2;
                        cnt_q    <= '0;
                        loaded_q <= 1'b0;
                    end
                end
                st_calc: begin
                    if (!loaded_q) begin
                        // First CALC cycle seeds the accumulator with magnitudes.
                        acc_q    <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                        opnd_q   <= is_div ? mag_b : mag_a;
                        loaded_q <= 1'b1;
                    end else begin
                        acc_q <= acc_step;
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                st_finish: res_q <= fin_val;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: a table of hand-computed vectors plus
// hand-written sequences for reset mid-operation and start storms.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int XLEN  = 32;
    localparam int BOUND = 100;

    logic clk;
    logic rst;

    muldiv_if #(.XLEN(XLEN)) bus ();

    muldiv_seq #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one operation from an idle unit and check result, latency, busy
    // coverage and the single-cycle done pulse. Returns at the negedge after done.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat, input string name);
        int          lat;
        int          busy_low;
        logic        seen;
        logic [31:0] want;
        logic [31:0] got;
        exp_q.push_back(exp);
        bus.start  = 1'b1;
        bus.funct3 = f;
        bus.rs1    = a;
        bus.rs2    = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat      = 0;
        busy_low = 0;
        seen     = 1'b0;
        while (!seen && lat < BOUND) begin
            @(negedge clk);
            lat++;
            if (!bus.busy) busy_low++;
            if (bus.done) seen = 1'b1;
        end
        want = exp_q.pop_front();
        got  = bus.result;
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " result"}, got, want);
        check({name, " busy gaps"}, 32'(busy_low), 32'd0);
        @(negedge clk);
        check({name, " done pulse"}, {30'd0, bus.done, bus.busy}, 32'd0);
        check({name, " result held"}, bus.result, want);
    endtask

    initial begin
        int          lat;
        int          gap;
        logic        seen;

        tbl.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul 7*-3"});
        tbl.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu max*max"});
        tbl.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34, "mulh -1*-1"});
        tbl.push_back('{3'd2, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, 34, "mulhsu -1*2"});
        tbl.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "mulhsu -1*umax"});
        tbl.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "mulh min*min"});
        tbl.push_back('{3'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, "mul min*-1"});
        tbl.push_back('{3'd3, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 34, "mulhu 2^16*2^16"});
        tbl.push_back('{3'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 34, "mul 2^16*2^16"});
        tbl.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 34, "div -7/2"});
        tbl.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 34, "rem -7/2"});
        tbl.push_back('{3'd5, 32'hFFFF_FFF9, 32'd2,          32'h7FFF_FFFC, 34, "divu -7/2"});
        tbl.push_back('{3'd7, 32'hFFFF_FFF9, 32'd2,          32'h0000_0001, 34, "remu -7/2"});
        tbl.push_back('{3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, "div 7/-2"});
        tbl.push_back('{3'd6, 32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 34, "rem 7/-2"});
        tbl.push_back('{3'd4, 32'd5,          32'd0,          32'hFFFF_FFFF, 1,  "div 5/0"});
        tbl.push_back('{3'd6, 32'd5,          32'd0,          32'h0000_0005, 1,  "rem 5/0"});
        tbl.push_back('{3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF, 1,  "divu 5/0"});
        tbl.push_back('{3'd7, 32'd5,          32'd0,          32'h0000_0005, 1,  "remu 5/0"});
        tbl.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  "div ovf"});
        tbl.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1,  "rem ovf"});
        tbl.push_back('{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34, "divu min/umax"});
        tbl.push_back('{3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, "remu min/umax"});
        tbl.push_back('{3'd4, 32'd100,        32'd7,          32'd14,        34, "div 100/7"});
        tbl.push_back('{3'd6, 32'd100,        32'd7,          32'd2,         34, "rem 100/7"});

        // Reset block.
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.funct3 = 3'd0;
        bus.rs1    = '0;
        bus.rs2    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset outputs", {30'd0, bus.busy, bus.done}, 32'd0);
        check("reset result", bus.result, 32'd0);
        check("reset state", 32'(bus.dbg_state), 32'(st_idle));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Table vectors; the first is issued on the first cycle out of reset.
        foreach (tbl[i]) begin
            run_op(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat, tbl[i].name);
        end

        // Reset at CALC iteration 10 (cycle 12 after the start cycle).
        bus.start  = 1'b1;
        bus.funct3 = 3'd0;
        bus.rs1    = 32'd9;
        bus.rs2    = 32'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (12) @(negedge clk);
        check("mid-calc state", 32'(bus.dbg_state), 32'(st_calc));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid-calc reset busy/done", {30'd0, bus.busy, bus.done}, 32'd0);
        check("mid-calc reset result", bus.result, 32'd0);
        run_op(3'd5, 32'd100, 32'd7, 32'd14, 34, "divu after reset");

        // Start held high through an operation: only the first is accepted.
        bus.start  = 1'b1;
        bus.funct3 = 3'd5;
        bus.rs1    = 32'd100;
        bus.rs2    = 32'd7;
        @(posedge clk);
        #1;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < BOUND) begin
            bus.funct3 = 3'($urandom_range(0, 7));
            bus.rs1    = $urandom_range(1, 1000);
            bus.rs2    = $urandom_range(1, 1000);
            @(negedge clk);
            lat++;
            if (bus.done) seen = 1'b1;
        end
        check("storm latency", 32'(lat), 32'd34);
        check("storm result", bus.result, 32'd14);
        // Start stays high in the done cycle (ignored) and the next (accepted).
        bus.funct3 = 3'd0;
        bus.rs1    = 32'd3;
        bus.rs2    = 32'd5;
        @(negedge clk);
        check("storm idle after done", {30'd0, bus.busy, bus.done}, 32'd0);
        check("storm result held", bus.result, 32'd14);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        gap  = 1;
        seen = 1'b0;
        while (!seen && gap < BOUND) begin
            @(negedge clk);
            gap++;
            if (bus.done) seen = 1'b1;
        end
        check("storm done-to-done gap", 32'(gap), 32'd35);
        check("storm second result", bus.result, 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter XLEN, default 32: operand and result width.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a new M-extension operation; sampled only in IDLE.
REQ-005 funct3  input  3  operation select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 rs1  input  XLEN  operand A (dividend / multiplicand).
REQ-007 rs2  input  XLEN  operand B (divisor / multiplier).
REQ-008 busy  output  1  high while an operation is in flight; the pipeline stalls on it.
REQ-009 done  output  1  one-cycle pulse; result valid in the same cycle.
REQ-010 result  output  XLEN  operation result; held stable from the done pulse until the next accepted start.

Function
REQ-011 FSM states are IDLE, CALC and FINISH.
REQ-012 IDLE: start=1 latches funct3, rs1 and rs2, and the FSM goes to CALC next cycle; otherwise it stays in IDLE.
REQ-013 Fast path: in IDLE, start=1 with divide-by-zero or signed overflow goes directly to FINISH.
REQ-014 CALC runs exactly XLEN iterations, one per cycle, using a 6-bit counter from 0 to XLEN-1; the FSM goes to FINISH after the last iteration.
REQ-015 Multiply: radix-2 shift-add on operand magnitudes into a 2*XLEN product, with sign fixed up at FINISH.
REQ-016 Multiply signedness: MUL and MULH treat both operands as signed; MULHSU treats rs1 as signed and rs2 as unsigned; MULHU treats both as unsigned.
REQ-017 Multiply result: MUL returns product[XLEN-1:0]; the MULH variants return product[2*XLEN-1:XLEN].
REQ-018 Divide: restoring division on magnitudes for DIV/REM and on raw operands for DIVU/REMU.
REQ-019 Divide sign rules: the quotient is negated when operand signs differ (signed ops only); the remainder takes the sign of the dividend.
REQ-020 Divide-by-zero (rs2=0): quotient is all ones; remainder is rs1.
REQ-021 Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): quotient 0x80000000; remainder 0.
REQ-022 FINISH lasts one cycle: done=1, result is updated, and the FSM returns to IDLE.
REQ-023 Latency: normal ops raise done exactly XLEN+2 cycles after the start cycle (34 for XLEN=32); fast-path ops raise done 1 cycle after.
REQ-024 busy is 1 in CALC and FINISH and 0 in IDLE.
REQ-025 start while busy=1 is ignored; operands are not re-latched.
REQ-026 start in the same cycle that done=1 is ignored; a new start is accepted the following cycle in IDLE.
REQ-027 Back-to-back ops: the result of op N remains stable until op N+1's done pulse.
REQ-028 Operations are independent: no MULH/MUL fusion and no result forwarding.

Reset
REQ-029 rst=1 at any clock edge, including mid-CALC, forces the FSM to IDLE.
REQ-030 Reset values: busy=0, done=0, result=0; counter, accumulator and latched operands are cleared.
REQ-031 The first start is accepted on the first cycle after rst deasserts.

Structure
REQ-032 Shared package muldiv_pkg SHALL hold:
- the funct3 enum (MUL..REMU);
- the FSM state enum;
- the overflow constant 0x80000000.
REQ-033 Sub-module muldiv_iter SHALL be purely combinational and compute one shift-add or restore-subtract step. It is instantiated once; sequencing, sign handling and special cases stay in muldiv_seq.
REQ-034 Target RTL size is 150-300 lines in total; no DSP inference or multi-cycle paths.

Verification
REQ-035 MUL with rs1=7, rs2=-3 (0xFFFFFFFD) -> result 0xFFFFFFEB, done at cycle 34, busy high for cycles 1-34.
REQ-036 MULHU with rs1=rs2=0xFFFFFFFF -> 0xFFFFFFFE; MULH with the same operands -> 0x00000000; MULHSU with rs1=-1, rs2=2 -> 0xFFFFFFFF.
REQ-037 Divide with rs1=-7, rs2=2 -> DIV gives 0xFFFFFFFD, REM gives 0xFFFFFFFF, DIVU gives 0x7FFFFFFC, REMU gives 1.
REQ-038 Divide-by-zero with rs1=5, rs2=0 -> DIV gives 0xFFFFFFFF and REM gives 5, each with done at cycle 1. Overflow case 0x80000000 / -1 -> DIV gives 0x80000000 and REM gives 0, each with done at cycle 1.
REQ-039 Assert rst at CALC iteration 10 -> next cycle busy=0, done=0, result=0. A start in the following cycle (e.g. DIVU 100/7) completes normally with result 14.
REQ-040 Pulse start every cycle during an operation -> only the first start is accepted and a single done pulse occurs. A start in the done cycle is ignored; a start the next cycle is accepted.
